// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: a small first-word-fall-through FIFO of
// {instruction, pc} pairs. It stalls fetch when full, empties on a redirect,
// and flags control-transfer instructions at the head for the branch logic.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64,
   parameter int ILEN  = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         if_valid,
   input  logic [ILEN-1:0]              if_instr,
   input  logic [XLEN-1:0]              if_pc,
   input  logic                         flush,
   output logic                         fq_stall,
   output logic                         dec_valid,
   input  logic                         dec_ready,
   output logic [ILEN-1:0]              dec_instr,
   output logic [XLEN-1:0]              dec_pc,
   output logic                         dec_is_ctrl,
   output logic [$clog2(DEPTH+1)-1:0]   fq_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

   logic [ILEN-1:0]  instr_mem [DEPTH];
   logic [XLEN-1:0]  pc_mem    [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             enq;
   logic             deq;
   logic [ILEN-1:0]  head_instr;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign enq       = if_valid & ~full & ~flush;
   assign deq       = dec_valid & dec_ready & ~flush;
   assign fq_stall  = full;
   assign dec_valid = ~empty;
   assign fq_count  = count;

   // Entry storage; never cleared, because the outputs are masked whenever the queue is empty
   always_ff @(posedge clk) begin
      if (enq) begin
         instr_mem[wr_ptr] <= if_instr;
         pc_mem[wr_ptr]    <= if_pc;
      end
   end

   // Pointers and occupancy; a flush discards everything, including any same-cycle enq or deq
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (enq && !deq) begin
            count <= count + CNT_W'(1);
         end else if (deq && !enq) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Head entry falls through to decode; an empty queue presents a NOP at pc 0
   always_comb begin
      head_instr  = NOP;
      dec_pc      = '0;
      dec_is_ctrl = 1'b0;
      if (!empty) begin
         head_instr  = instr_mem[rd_ptr];
         dec_pc      = pc_mem[rd_ptr];
         dec_is_ctrl = (head_instr[6:0] == 7'b1100011) ||
                       (head_instr[6:0] == 7'b1101111) ||
                       (head_instr[6:0] == 7'b1100111);
      end
      dec_instr = head_instr;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected entries, a monitor
// pops and compares them on every accepted handshake.
module tb_fetch_queue;

   logic        clk;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        flush;
   logic        fq_stall;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [63:0] dec_pc;
   logic        dec_is_ctrl;
   logic [2:0]  fq_count;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
      logic        ctrl;
   } entry_t;

   entry_t exp_q[$];
   int     assertions = 0;
   int     failures   = 0;

   fetch_queue #(.DEPTH(4), .XLEN(64), .ILEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .flush       (flush),
      .fq_stall    (fq_stall),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_instr   (dec_instr),
      .dec_pc      (dec_pc),
      .dec_is_ctrl (dec_is_ctrl),
      .fq_count    (fq_count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Runaway guard
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertions++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Non-control-flow instruction tagged with its pc (opcode 0010011)
   function automatic logic [31:0] mk_instr(input logic [63:0] pc);
      return {pc[19:0], 12'h013};
   endfunction

   // Drive one cycle of inputs, record the expected enqueue, then step past the edge
   task automatic apply_stimulus(input logic iv, input logic [63:0] pc, input logic [31:0] instr,
                                 input logic rdy, input logic fl, input logic push, input logic ctrl);
      entry_t e;
      if_valid  = iv;
      if_pc     = pc;
      if_instr  = instr;
      dec_ready = rdy;
      flush     = fl;
      if (fl) begin
         exp_q.delete();
      end
      if (push) begin
         e.instr = instr;
         e.pc    = pc;
         e.ctrl  = ctrl;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted head entry must match the oldest expected entry
   always @(negedge clk) begin
      entry_t e;
      if (rst_n && dec_valid && dec_ready && !flush) begin
         if (exp_q.size() == 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL deq_unexpected: got pc %0h expected no entry", dec_pc);
         end else begin
            e = exp_q.pop_front();
            check_output("sb_pc", dec_pc, e.pc);
            check_output("sb_instr", {32'h0, dec_instr}, {32'h0, e.instr});
            check_output("sb_is_ctrl", {63'h0, dec_is_ctrl}, {63'h0, e.ctrl});
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      if_valid  = 1'b0;
      if_instr  = '0;
      if_pc     = '0;
      flush     = 1'b0;
      dec_ready = 1'b0;

      // Reset values while held in reset
      #12;
      check_output("rst_valid", {63'h0, dec_valid}, 64'h0);
      check_output("rst_stall", {63'h0, fq_stall}, 64'h0);
      check_output("rst_count", {61'h0, fq_count}, 64'h0);
      check_output("rst_instr", {32'h0, dec_instr}, 64'h13);
      check_output("rst_pc", dec_pc, 64'h0);
      check_output("rst_is_ctrl", {63'h0, dec_is_ctrl}, 64'h0);
      #4;
      rst_n = 1'b1;

      // Fill: four entries accepted, the fifth ignored while full
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, 64'(i * 4), mk_instr(64'(i * 4)), 1'b0, 1'b0, (i < 4), 1'b0);
         check_output("fill_count", {61'h0, fq_count}, (i < 4) ? 64'(i + 1) : 64'd4);
         check_output("fill_stall", {63'h0, fq_stall}, (i >= 3) ? 64'd1 : 64'd0);
         check_output("fill_head_pc", dec_pc, 64'h0);
      end

      // Drain: stall holds during the full+deq cycle and drops after the edge
      if_valid  = 1'b0;
      dec_ready = 1'b1;
      #1;
      check_output("drain_stall_before", {63'h0, fq_stall}, 64'd1);
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
         check_output("drain_count", {61'h0, fq_count}, 64'(3 - i));
         check_output("drain_stall", {63'h0, fq_stall}, 64'h0);
         if (i < 3) begin
            check_output("drain_head_pc", dec_pc, 64'(4 * (i + 1)));
         end
      end
      check_output("drain_valid", {63'h0, dec_valid}, 64'h0);

      // Concurrent enq+deq with pointer wrap
      apply_stimulus(1'b1, 64'h100, mk_instr(64'h100), 1'b0, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b1, 64'h104, mk_instr(64'h104), 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 64'(64'h108 + 4 * i), mk_instr(64'(64'h108 + 4 * i)), 1'b1, 1'b0, 1'b1, 1'b0);
         check_output("conc_count", {61'h0, fq_count}, 64'd2);
         check_output("conc_head_pc", dec_pc, 64'(64'h104 + 4 * i));
      end
      apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("conc_empty", {61'h0, fq_count}, 64'd0);

      // Flush with a concurrent fetch: nothing of that cycle survives
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 64'(64'h200 + 4 * i), mk_instr(64'(64'h200 + 4 * i)), 1'b0, 1'b0, 1'b1, 1'b0);
      end
      check_output("pre_flush_count", {61'h0, fq_count}, 64'd3);
      apply_stimulus(1'b1, 64'h28, mk_instr(64'h28), 1'b1, 1'b1, 1'b0, 1'b0);
      check_output("flush_count", {61'h0, fq_count}, 64'd0);
      check_output("flush_valid", {63'h0, dec_valid}, 64'd0);
      check_output("flush_instr", {32'h0, dec_instr}, 64'h13);
      apply_stimulus(1'b1, 64'h28, mk_instr(64'h28), 1'b0, 1'b0, 1'b1, 1'b0);
      check_output("post_flush_pc", dec_pc, 64'h28);
      check_output("post_flush_count", {61'h0, fq_count}, 64'd1);
      apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_output("empty_flush_count", {61'h0, fq_count}, 64'd0);

      // Predecode of a branch, then a plain addi
      apply_stimulus(1'b1, 64'h300, 32'hFE000AE3, 1'b0, 1'b0, 1'b1, 1'b1);
      check_output("beq_is_ctrl", {63'h0, dec_is_ctrl}, 64'd1);
      apply_stimulus(1'b1, 64'h304, 32'h00500113, 1'b0, 1'b0, 1'b1, 1'b0);
      check_output("beq_still_head", {63'h0, dec_is_ctrl}, 64'd1);
      apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("addi_pc", dec_pc, 64'h304);
      check_output("addi_is_ctrl", {63'h0, dec_is_ctrl}, 64'd0);

      // Asynchronous reset mid-cycle with one entry still queued
      dec_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_output("async_rst_valid", {63'h0, dec_valid}, 64'd0);
      check_output("async_rst_count", {61'h0, fq_count}, 64'd0);
      check_output("async_rst_instr", {32'h0, dec_instr}, 64'h13);
      #3;
      rst_n = 1'b1;
      apply_stimulus(1'b1, 64'h400, mk_instr(64'h400), 1'b0, 1'b0, 1'b1, 1'b0);
      check_output("after_rst_pc", dec_pc, 64'h400);
      check_output("after_rst_count", {61'h0, fq_count}, 64'd1);
      apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("final_count", {61'h0, fq_count}, 64'd0);
      check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
